// File: rtl/mlp_mem_pkg.sv
// mlp_mem_pkg: FSM states, requester indices and grant encoding shared by the SRAM arbiter slice
package mlp_mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;
  localparam int LOADER = 0;
  localparam int ENGINE = 1;
  function automatic logic [1:0] onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester bus (req/we/addr/wdata in, gnt/done/err/rdata out) and SRAM bus (re/we/addr/wdata out, rdata in)
interface sram_arbiter_if #(parameter int NUM_BIT = 8, parameter int ADDR_W = 4);
  logic [1:0]              req_i;
  logic [1:0]              we_i;
  logic [1:0][ADDR_W-1:0]  addr_i;
  logic [1:0][NUM_BIT-1:0] wdata_i;
  logic [1:0]              gnt_o;
  logic [1:0]              done_o;
  logic [1:0]              err_o;
  logic [NUM_BIT-1:0]      rdata_o;
  logic                    sram_re_o;
  logic                    sram_we_o;
  logic [ADDR_W-1:0]       sram_addr_o;
  logic [NUM_BIT-1:0]      sram_wdata_o;
  logic [NUM_BIT-1:0]      sram_rdata_i;
  modport slave (
    input  req_i, we_i, addr_i, wdata_i, sram_rdata_i,
    output gnt_o, done_o, err_o, rdata_o, sram_re_o, sram_we_o, sram_addr_o, sram_wdata_o
  );
  modport master (
    output req_i, we_i, addr_i, wdata_i, sram_rdata_i,
    input  gnt_o, done_o, err_o, rdata_o, sram_re_o, sram_we_o, sram_addr_o, sram_wdata_o
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin; ports clk, rst_n, req (requests), en (grant taken), gnt (one-hot winner)
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last;
  assign gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
  // last starts at 1 so port 0 wins the first contended grant
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (en) last <= gnt[1];
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM between loader (0) and engine (1); ports clk, rst_n, bus (slave side of sram_arbiter_if)
module sram_arbiter
  import mlp_mem_pkg::*;
#(
  parameter int NUM_BIT = 8,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16
) (
  input logic          clk,
  input logic          rst_n,
  sram_arbiter_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  state_t              state, state_nx;
  logic [1:0]          win;
  logic                take, sel, port, we_q, oor_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NUM_BIT-1:0]  wdata_q, rdata_q;
  assign take = (state == IDLE) && |bus.req_i;
  assign sel  = win[ENGINE];
  rr_arbiter2 u_arb (.clk(clk), .rst_n(rst_n), .req(bus.req_i), .en(take), .gnt(win));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == IDLE) ? (take ? ACCESS : IDLE) : (state == ACCESS) ? COMPLETE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      port    <= 1'b0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (take) begin
        port    <= sel;
        we_q    <= bus.we_i[sel];
        oor_q   <= {1'b0, bus.addr_i[sel]} >= DEPTH_L;
        addr_q  <= bus.addr_i[sel];
        wdata_q <= bus.wdata_i[sel];
      end
      if (state == ACCESS && !we_q && !oor_q) rdata_q <= bus.sram_rdata_i;
    end
  // addr/wdata come straight from the latch so they hold through COMPLETE
  assign bus.gnt_o        = (state != IDLE) ? onehot(port) : 2'b00;
  assign bus.done_o       = (state == COMPLETE) ? onehot(port) : 2'b00;
  assign bus.err_o        = bus.done_o & {2{oor_q}};
  assign bus.sram_we_o    = (state == ACCESS) && we_q && !oor_q;
  assign bus.sram_re_o    = (state == ACCESS) && !we_q && !oor_q;
  assign bus.sram_addr_o  = addr_q;
  assign bus.sram_wdata_o = wdata_q;
  assign bus.rdata_o      = rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized and directed scoreboard bench for sram_arbiter against a transaction-level model
module tb_sram_arbiter;
  localparam int DEPTH = 15;
  typedef struct {
    logic       port;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       err;
    logic [7:0] rdata;
    int         acc;
  } txn_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  txn_t q[$];
  int done_log[$];
  logic [7:0] sram_mem [16] = '{default: '0};
  logic [7:0] ref_mem [16] = '{default: '0};
  sram_arbiter_if #(.NUM_BIT(8), .ADDR_W(4)) bus ();
  sram_arbiter #(.NUM_BIT(8), .ADDR_W(4), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.sram_we_o) sram_mem[bus.sram_addr_o] <= bus.sram_wdata_o;
  assign bus.sram_rdata_i = sram_mem[bus.sram_addr_o];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction at a time, three edges each, round-robin on contention
  int   busy = 0;
  logic last = 1'b1;
  logic [7:0] exp_rdata = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      busy = 0;
      last = 1'b1;
      exp_rdata = '0;
    end else begin
      txn_t t;
      logic [1:0] r;
      cyc++;
      r = bus.req_i;
      if (busy > 0) busy--;
      else if (r != 2'b00) begin
        t.port  = (r == 2'b11) ? !last : r[1];
        t.we    = bus.we_i[t.port];
        t.addr  = bus.addr_i[t.port];
        t.wdata = bus.wdata_i[t.port];
        t.err   = int'(t.addr) >= DEPTH;
        if (!t.err) begin
          if (t.we) ref_mem[t.addr] = t.wdata;
          else exp_rdata = ref_mem[t.addr];
        end
        t.rdata = exp_rdata;
        t.acc   = cyc;
        q.push_back(t);
        last = t.port;
        busy = 2;
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    txn_t t;
    if (q.size() > 0 && cyc == q[0].acc) begin
      check("access_we", bus.sram_we_o, q[0].we && !q[0].err);
      check("access_re", bus.sram_re_o, !q[0].we && !q[0].err);
      check("access_addr", bus.sram_addr_o, q[0].addr);
      if (q[0].we) check("access_wdata", bus.sram_wdata_o, q[0].wdata);
      check("access_gnt", bus.gnt_o, q[0].port ? 2'b10 : 2'b01);
      check("access_done", bus.done_o, 2'b00);
    end else check("idle_enables", {bus.sram_we_o, bus.sram_re_o}, 2'b00);
    if (bus.done_o != 2'b00 || (q.size() > 0 && cyc == q[0].acc + 1)) begin
      if (q.size() == 0) check("unexpected_done", bus.done_o, 2'b00);
      else begin
        t = q.pop_front();
        check("done", bus.done_o, t.port ? 2'b10 : 2'b01);
        check("done_latency", cyc, t.acc + 1);
        check("err", bus.err_o, t.err ? (t.port ? 2'b10 : 2'b01) : 2'b00);
        check("rdata", bus.rdata_o, t.rdata);
        check("complete_gnt", bus.gnt_o, t.port ? 2'b10 : 2'b01);
        check("complete_addr", bus.sram_addr_o, t.addr);
        done_log.push_back(int'(t.port));
      end
    end
  end

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    @(posedge clk);
    #2;
    bus.req_i = r;
    bus.we_i = w;
    bus.addr_i = {a1, a0};
    bus.wdata_i = {d1, d0};
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'b00, 2'b00, 4'd0, 4'd0, 8'd0, 8'd0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_gnt"}, bus.gnt_o, 0);
    check({nm, "_done"}, bus.done_o, 0);
    check({nm, "_err"}, bus.err_o, 0);
    check({nm, "_re"}, bus.sram_re_o, 0);
    check({nm, "_we"}, bus.sram_we_o, 0);
    check({nm, "_addr"}, bus.sram_addr_o, 0);
    check({nm, "_wdata"}, bus.sram_wdata_o, 0);
    check({nm, "_rdata"}, bus.rdata_o, 0);
  endtask

  initial begin
    bus.req_i = '0;
    bus.we_i = '0;
    bus.addr_i = '0;
    bus.wdata_i = '0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00);
    idle(3);
    drive(2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00);
    idle(3);
    drive(2'b01, 2'b01, 4'd0, 4'd0, 8'hFF, 8'h00);
    idle(3);
    drive(2'b01, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    idle(3);
    drive(2'b10, 2'b00, 4'd0, 4'd15, 8'h00, 8'h00);
    idle(4);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    done_log.delete();
    repeat (12) drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00);
    idle(4);
    check("rr_count", done_log.size() >= 4, 1);
    if (done_log.size() >= 4) begin
      check("rr_order0", done_log[0], 0);
      check("rr_order1", done_log[1], 1);
      check("rr_order2", done_log[2], 0);
      check("rr_order3", done_log[3], 1);
    end
    drive(2'b10, 2'b00, 4'd0, 4'd5, 8'h00, 8'h00);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.req_i = 2'b11;
    bus.we_i = 2'b00;
    #1;
    check_all_zero("abort");
    done_log.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    idle(4);
    check("abort_count", done_log.size() >= 2, 1);
    if (done_log.size() >= 2) begin
      check("abort_first", done_log[0], 0);
      check("abort_second", done_log[1], 1);
    end
    repeat (300) drive(2'($urandom), 2'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       8'($urandom), 8'($urandom));
    idle(6);
    check("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
